cycle_controller: RTL

CYCLE_CONTROLLER -- requirements
Module: cycle_controller

---
 rtl/cycle_controller.sv | 101 ++++++++++
 1 files changed

// File: rtl/cycle_controller.sv
// Instruction-cycle sequencer: fetch, decode and execute with memory-ready waits.
// Strobes are decoded from state; only mem_ready gates them combinationally.
//   state     | meaning
//   HALT      | idle, waiting for start
//   FETCH_AR  | T0: load AR from PC
//   FETCH_MEM | T1: read IR, wait for mem_ready
//   DECODE    | T2: latch opcode, choose HALT or EXEC
//   EXEC      | T3: execute, MEM_OP waits for mem_ready
module cycle_controller #(
  parameter int              OP_W   = 3,
  parameter logic [OP_W-1:0] HLT_OP = 3'b111,
  parameter logic [OP_W-1:0] MEM_OP = 3'b110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic [1:0]      t,
  output logic            ar_ld,
  output logic            mem_rd,
  output logic            ir_ld,
  output logic            pc_inc,
  output logic            exec_en,
  output logic            halted
);

  typedef enum logic [2:0] {
    HALT      = 3'd0,
    FETCH_AR  = 3'd1,
    FETCH_MEM = 3'd2,
    DECODE    = 3'd3,
    EXEC      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HALT;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    t       = 2'd0;
    ar_ld   = 1'b0;
    mem_rd  = 1'b0;
    ir_ld   = 1'b0;
    pc_inc  = 1'b0;
    exec_en = 1'b0;
    halted  = 1'b0;
    case (state_q)
      HALT: begin
        halted = 1'b1;
        if (start) state_d = FETCH_AR;
      end
      FETCH_AR: begin
        t       = 2'd0;
        ar_ld   = 1'b1;
        state_d = FETCH_MEM;
      end
      FETCH_MEM: begin
        t      = 2'd1;
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        t       = 2'd2;
        op_d    = opcode;
        state_d = (opcode == HLT_OP) ? HALT : EXEC;
      end
      EXEC: begin
        t = 2'd3;
        // Only the opcode latched in DECODE steers execution.
        if (op_q == MEM_OP) begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            exec_en = 1'b1;
            state_d = FETCH_AR;
          end
        end else begin
          exec_en = 1'b1;
          state_d = FETCH_AR;
        end
      end
      default: state_d = HALT;
    endcase
  end

endmodule
